// File: rtl/rs_pkg.sv
// Shared constants and FSM encoding for the RS output stage.
package rs_pkg;

  localparam int         RS_CW_WORDS = 24;
  localparam int         RS_BLK_W    = 66;
  localparam logic [1:0] RS_SH_DATA  = 2'b01;
  localparam logic [1:0] RS_SH_CTRL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } rs_state_e;

  function automatic logic [1:0] rs_sync_hdr(input logic isos);
    return isos ? RS_SH_CTRL : RS_SH_DATA;
  endfunction

endpackage

// File: rtl/rs_blk_fifo.sv
// Synchronous FIFO with registered first-word-fall-through output.
module rs_blk_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             empty,
  output logic             wr_drop,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full, rd_fire, wr_fire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = rd_en & ~empty;
  // A read in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign wr_fire = wr_en & (~full | rd_fire);
  assign wr_drop = wr_en & full & ~rd_fire;
  assign rd_data = dout_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    // The entry being written becomes the new head when the FIFO is (or just went) empty.
    if (wr_fire && (rd_ptr_d == wr_ptr_q)) dout_d = wr_data;
    else                                    dout_d = mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/rs_blk_out.sv
// RS output stage: schedules 24-word pop bursts and rebuilds 66-bit blocks.
// Optional statistics counters are enabled with RS_BLK_OUT_STAT_EN.
//   state | meaning
//   IDLE  | no burst; wait for a pending codeword and enough FIFO credit
//   POP   | pop_data_ena high, one word per cycle for CW_WORDS cycles
//   GAP   | one cycle with pop_data_ena low; may re-arm straight into POP
module rs_blk_out
  import rs_pkg::*;
#(
  parameter int CW_WORDS   = RS_CW_WORDS,
  parameter int FIFO_DEPTH = 32,
  parameter int FIFO_AW    = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cw_done,
  output logic                pop_data_ena,
  input  logic                rs_pop_data_vld,
  input  logic [63:0]         rs_pop_data,
  input  logic                rs_pop_isos,
  output logic                blk_vld,
  output logic [RS_BLK_W-1:0] blk_data,
  input  logic                blk_rdy,
  output logic                pair_err,
  output logic                ovf_err
`ifdef RS_BLK_OUT_STAT_EN
  ,
  output logic [31:0]         stat_blk_cnt,
  output logic [15:0]         stat_pair_err_cnt
`endif
);

  localparam int CNT_W = $clog2(CW_WORDS);

  rs_state_e        state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [FIFO_AW:0] rsv_q, rsv_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0] wr_idx_q, wr_idx_d;
  logic             pop_ena_q, pop_ena_d;
  logic             isos_lat_q, isos_lat_d;
  logic             pair_err_q, pair_err_d;
  logic             ovf_q, ovf_d;
  logic             fifo_empty, wr_drop, blk_fire, credit_ok, start;

  assign blk_vld      = ~fifo_empty;
  assign blk_fire     = blk_vld & blk_rdy;
  assign pop_data_ena = pop_ena_q;
  assign pair_err     = pair_err_q;
  assign ovf_err      = ovf_q;

  // Reserved entries include words still in flight, so a burst only starts when all 24 fit.
  assign credit_ok = (rsv_q <= (FIFO_AW+1)'(FIFO_DEPTH - CW_WORDS));
  assign start     = ((state_q == ST_IDLE) || (state_q == ST_GAP)) && (pend_q != 2'd0) && credit_ok;

  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_POP;
        pop_cnt_d = '0;
      end
      ST_POP: begin
        pop_cnt_d = pop_cnt_q + 1'b1;
        if (pop_cnt_q == CNT_W'(CW_WORDS - 1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d   = start ? ST_POP : ST_IDLE;
        pop_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    pop_ena_d = (state_d == ST_POP);
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q | wr_drop;
    case ({cw_done, start})
      2'b10: if (pend_q == 2'd3) ovf_d = 1'b1;
             else                pend_d = pend_q + 2'd1;
      2'b01: pend_d = pend_q - 2'd1;
      default: ;
    endcase

    rsv_d = rsv_q;
    case ({pop_ena_q, blk_fire})
      2'b10:   rsv_d = rsv_q + 1'b1;
      2'b01:   rsv_d = rsv_q - 1'b1;
      default: ;
    endcase

    wr_idx_d   = wr_idx_q;
    isos_lat_d = isos_lat_q;
    pair_err_d = 1'b0;
    if (rs_pop_data_vld) begin
      wr_idx_d = (wr_idx_q == CNT_W'(CW_WORDS - 1)) ? '0 : wr_idx_q + 1'b1;
      if (!wr_idx_q[0]) isos_lat_d = rs_pop_isos;
      else              pair_err_d = (rs_pop_isos != isos_lat_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      rsv_q      <= '0;
      pop_cnt_q  <= '0;
      wr_idx_q   <= '0;
      pop_ena_q  <= 1'b0;
      isos_lat_q <= 1'b0;
      pair_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rsv_q      <= rsv_d;
      pop_cnt_q  <= pop_cnt_d;
      wr_idx_q   <= wr_idx_d;
      pop_ena_q  <= pop_ena_d;
      isos_lat_q <= isos_lat_d;
      pair_err_q <= pair_err_d;
      ovf_q      <= ovf_d;
    end
  end

  rs_blk_fifo #(
    .WIDTH (RS_BLK_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (rs_pop_data_vld),
    .wr_data ({rs_sync_hdr(rs_pop_isos), rs_pop_data}),
    .rd_en   (blk_rdy),
    .empty   (fifo_empty),
    .wr_drop (wr_drop),
    .rd_data (blk_data)
  );

`ifdef RS_BLK_OUT_STAT_EN
  logic [31:0] stat_blk_q, stat_blk_d;
  logic [15:0] stat_pe_q, stat_pe_d;

  always_comb begin
    stat_blk_d = stat_blk_q + 32'(blk_fire);
    stat_pe_d  = stat_pe_q + 16'(pair_err_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_blk_q <= '0;
      stat_pe_q  <= '0;
    end else begin
      stat_blk_q <= stat_blk_d;
      stat_pe_q  <= stat_pe_d;
    end
  end

  assign stat_blk_cnt      = stat_blk_q;
  assign stat_pair_err_cnt = stat_pe_q;
`endif

endmodule

// File: tb/tb_rs_blk_out.sv
// Directed bench for rs_blk_out: upstream pop model, per-cycle history, block scoreboard.
module tb_rs_blk_out;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cw_done = 1'b0;
  logic        pop_data_ena;
  logic        rs_pop_data_vld = 1'b0;
  logic [63:0] rs_pop_data = '0;
  logic        rs_pop_isos = 1'b0;
  logic        blk_vld;
  logic [65:0] blk_data;
  logic        blk_rdy = 1'b0;
  logic        pair_err;
  logic        ovf_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] isos_pat = '0;

  rs_blk_out dut (
    .clk             (clk),
    .rstn            (rstn),
    .cw_done         (cw_done),
    .pop_data_ena    (pop_data_ena),
    .rs_pop_data_vld (rs_pop_data_vld),
    .rs_pop_data     (rs_pop_data),
    .rs_pop_isos     (rs_pop_isos),
    .blk_vld         (blk_vld),
    .blk_data        (blk_data),
    .blk_rdy         (blk_rdy),
    .pair_err        (pair_err),
    .ovf_err         (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_data(input int unsigned s);
    return {16'hBEEF, 16'h0000, s};
  endfunction

  function automatic logic [65:0] exp_blk(input int k);
    logic [1:0] h;
    h = isos_pat[k % 24] ? 2'b10 : 2'b01;
    return {h, mk_data(k)};
  endfunction

  // Upstream FIFO: returns a word exactly one cycle after each pop request.
  logic        ena_prev = 1'b0;
  int unsigned up_seq = 0;
  int          up_idx = 0;
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      ena_prev = 1'b0; rs_pop_data_vld = 1'b0; up_seq = 0; up_idx = 0;
    end else begin
      rs_pop_data_vld = ena_prev;
      if (ena_prev) begin
        rs_pop_data = mk_data(up_seq);
        rs_pop_isos = isos_pat[up_idx];
        up_seq++;
        up_idx = (up_idx == 23) ? 0 : up_idx + 1;
      end
      ena_prev = pop_data_ena;
    end
  end

  logic        ena_hist[$], cw_hist[$], hs_hist[$], vld_hist[$], pe_hist[$];
  logic [65:0] got_q[$];
  always @(negedge clk) begin
    if (rstn) begin
      ena_hist.push_back(pop_data_ena);
      cw_hist.push_back(cw_done);
      hs_hist.push_back(blk_vld && blk_rdy);
      vld_hist.push_back(rs_pop_data_vld);
      pe_hist.push_back(pair_err);
      if (blk_vld && blk_rdy) got_q.push_back(blk_data);
    end
  end

  int nb;
  int bst [8];
  int bln [8];

  task automatic get_bursts();
    nb = 0;
    for (int i = 0; i < 8; i++) begin bst[i] = 0; bln[i] = 0; end
    for (int i = 0; i < ena_hist.size(); i++) begin
      if (ena_hist[i] && (i == 0 || !ena_hist[i-1])) begin
        if (nb < 8) bst[nb] = i;
        nb++;
      end
      if (ena_hist[i] && nb > 0 && nb <= 8) bln[nb-1]++;
    end
  endtask

  function automatic int first_cw();
    for (int i = 0; i < cw_hist.size(); i++) if (cw_hist[i]) return i;
    return -100;
  endfunction

  function automatic int count_pe();
    int c = 0;
    foreach (pe_hist[i]) if (pe_hist[i]) c++;
    return c;
  endfunction

  task automatic clear_hist();
    ena_hist.delete(); cw_hist.delete(); hs_hist.delete();
    vld_hist.delete(); pe_hist.delete(); got_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; cw_done = 1'b0;
    repeat (2) @(negedge clk);
    clear_hist();
    rstn = 1'b1;
  endtask

  task automatic pulse_cw(input int n);
    @(posedge clk); #1; cw_done = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    cw_done = 1'b0;
  endtask

  task automatic wait_blocks(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_blocks(input string nm, input int n);
    n_cmp++;
    if (got_q.size() !== n) begin
      n_bad++; $display("FAIL %s_count: got %0d blocks, want %0d", nm, got_q.size(), n);
    end
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_blk(k)) begin
        n_bad++; $display("FAIL %s_blk%0d: got %h want %h", nm, k, got_q[k], exp_blk(k));
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    n_cmp++; if (pop_data_ena !== 1'b0) begin n_bad++; $display("FAIL reset_pop_ena: got %b want 0", pop_data_ena); end
    n_cmp++; if (blk_vld !== 1'b0) begin n_bad++; $display("FAIL reset_blk_vld: got %b want 0", blk_vld); end
    n_cmp++; if (blk_data !== 66'h0) begin n_bad++; $display("FAIL reset_blk_data: got %h want 0", blk_data); end
    n_cmp++; if (pair_err !== 1'b0) begin n_bad++; $display("FAIL reset_pair_err: got %b want 0", pair_err); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_err: got %b want 0", ovf_err); end
  endtask

  task automatic test_single_burst();
    for (int i = 0; i < 24; i++) isos_pat[i] = ((i / 2) % 2 == 0);
    do_reset();
    blk_rdy = 1'b1;
    pulse_cw(1);
    wait_blocks(24, 150);
    repeat (20) @(negedge clk);
    get_bursts();
    n_cmp++; if (nb !== 1) begin n_bad++; $display("FAIL single_nbursts: got %0d want 1", nb); end
    n_cmp++; if (bln[0] !== 24) begin n_bad++; $display("FAIL single_len: got %0d want 24", bln[0]); end
    n_cmp++; if (bst[0] - first_cw() !== 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", bst[0] - first_cw()); end
    n_cmp++; if (count_pe() !== 0) begin n_bad++; $display("FAIL single_pair_err: got %0d want 0", count_pe()); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL single_ovf: got %b want 0", ovf_err); end
    check_blocks("single", 24);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) isos_pat[i] = ((i / 2) % 2 == 0);
    do_reset();
    blk_rdy = 1'b1;
    pulse_cw(3);
    wait_blocks(72, 300);
    repeat (20) @(negedge clk);
    get_bursts();
    n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL b2b_nbursts: got %0d want 3", nb); end
    for (int b = 0; b < 3; b++) begin
      n_cmp++; if (bln[b] !== 24) begin n_bad++; $display("FAIL b2b_len%0d: got %0d want 24", b, bln[b]); end
    end
    for (int b = 1; b < 3; b++) begin
      n_cmp++;
      if (bst[b] - (bst[b-1] + bln[b-1]) !== 1) begin
        n_bad++; $display("FAIL b2b_gap%0d: got %0d want 1", b, bst[b] - (bst[b-1] + bln[b-1]));
      end
    end
    check_blocks("b2b", 72);
  endtask

  task automatic test_blocked_credit();
    int hs_before;
    for (int i = 0; i < 24; i++) isos_pat[i] = i[0];
    do_reset();
    blk_rdy = 1'b0;
    pulse_cw(2);
    repeat (60) @(negedge clk);
    get_bursts();
    n_cmp++; if (nb !== 1) begin n_bad++; $display("FAIL blocked_hold_nbursts: got %0d want 1", nb); end
    n_cmp++; if (blk_vld !== 1'b1) begin n_bad++; $display("FAIL blocked_vld: got %b want 1", blk_vld); end
    @(posedge clk); #1; blk_rdy = 1'b1;
    wait_blocks(48, 300);
    get_bursts();
    n_cmp++; if (nb !== 2) begin n_bad++; $display("FAIL blocked_nbursts: got %0d want 2", nb); end
    n_cmp++; if (bln[1] !== 24) begin n_bad++; $display("FAIL blocked_len2: got %0d want 24", bln[1]); end
    // Handshakes completed on edges before the one that raises the second burst.
    hs_before = 0;
    for (int j = 0; j < bst[1] - 1 && j < hs_hist.size(); j++) if (hs_hist[j]) hs_before++;
    n_cmp++; if (hs_before !== 16) begin n_bad++; $display("FAIL blocked_drain: got %0d want 16", hs_before); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL blocked_ovf: got %b want 0", ovf_err); end
    check_blocks("blocked", 48);
  endtask

  task automatic test_pair_err();
    int nv, jv, jp;
    isos_pat = 24'h0;
    isos_pat[5] = 1'b1;
    do_reset();
    blk_rdy = 1'b1;
    pulse_cw(1);
    wait_blocks(24, 150);
    nv = 0; jv = -1; jp = -1;
    for (int j = 0; j < vld_hist.size(); j++) begin
      if (vld_hist[j]) begin
        if (nv == 5) jv = j;
        nv++;
      end
      if (pe_hist[j] && jp < 0) jp = j;
    end
    n_cmp++; if (count_pe() !== 1) begin n_bad++; $display("FAIL pair_count: got %0d want 1", count_pe()); end
    n_cmp++; if (jp - jv !== 1) begin n_bad++; $display("FAIL pair_timing: got %0d want 1", jp - jv); end
    n_cmp++; if (got_q.size() > 5 && got_q[5][65:64] !== 2'b10) begin n_bad++; $display("FAIL pair_hdr5: got %b want 10", got_q[5][65:64]); end
    n_cmp++; if (got_q.size() > 4 && got_q[4][65:64] !== 2'b01) begin n_bad++; $display("FAIL pair_hdr4: got %b want 01", got_q[4][65:64]); end
    check_blocks("pair", 24);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 24; i++) isos_pat[i] = (i % 3 == 0);
    do_reset();
    blk_rdy = 1'b0;
    pulse_cw(1);
    repeat (35) @(negedge clk);
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %b want 0", ovf_err); end
    pulse_cw(4);
    repeat (2) @(negedge clk);
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    @(posedge clk); #1; blk_rdy = 1'b1;
    wait_blocks(96, 600);
    repeat (20) @(negedge clk);
    get_bursts();
    n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL ovf_nbursts: got %0d want 4 (pend saturates at 3)", nb); end
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
    check_blocks("ovf", 96);
    rstn = 1'b0;
    #1;
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL ovf_reset: got %b want 0", ovf_err); end
  endtask

  task automatic test_reset_mid_burst();
    int ones, c;
    for (int i = 0; i < 24; i++) isos_pat[i] = ((i / 2) % 2 == 0);
    do_reset();
    blk_rdy = 1'b1;
    pulse_cw(1);
    ones = 0; c = 0;
    while (ones < 11 && c < 50) begin
      @(negedge clk); c++;
      if (pop_data_ena) ones++;
    end
    n_cmp++; if (ones !== 11) begin n_bad++; $display("FAIL midrst_reach: got %0d pops want 11", ones); end
    #2; rstn = 1'b0;
    #1;
    n_cmp++; if (pop_data_ena !== 1'b0) begin n_bad++; $display("FAIL midrst_pop_ena: got %b want 0", pop_data_ena); end
    n_cmp++; if (blk_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_blk_vld: got %b want 0", blk_vld); end
    repeat (2) @(negedge clk);
    clear_hist();
    rstn = 1'b1;
    pulse_cw(1);
    wait_blocks(24, 150);
    repeat (20) @(negedge clk);
    get_bursts();
    n_cmp++; if (nb !== 1) begin n_bad++; $display("FAIL midrst_nbursts: got %0d want 1", nb); end
    n_cmp++; if (bln[0] !== 24) begin n_bad++; $display("FAIL midrst_len: got %0d want 24", bln[0]); end
    n_cmp++; if (bst[0] - first_cw() !== 2) begin n_bad++; $display("FAIL midrst_latency: got %0d want 2", bst[0] - first_cw()); end
    check_blocks("midrst", 24);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_blocked_credit();
    test_pair_err();
    test_overflow();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
